// File: rtl/exp_pkg.sv
// Shared types and constants for the e^x - 1 evaluator and its multiply-add step.
package exp_pkg;

  localparam int W_DEF = 17;
  localparam int N_DEF = 5;

  typedef logic signed [W_DEF:0]       word_t;
  typedef logic signed [2*W_DEF+1:0]   prod_t;

  // Taylor coefficients of e^x - 1 in Q16, index = power of x
  localparam word_t P [0:N_DEF] = '{
    18'sd0, 18'sd65536, 18'sd32768, 18'sd10923, 18'sd2731, 18'sd546
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exp_mac_step.sv
// One Horner step: s_next = ((x * s) >>> 16) + c, floor shift then truncation to the word width.
module exp_mac_step
  import exp_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = 16
) (
  input  logic signed [W:0] x_i,
  input  logic signed [W:0] s_i,
  input  logic signed [W:0] c_i,
  output logic signed [W:0] s_next_o
);

  logic signed [2*W+1:0] prod;
  logic signed [W:0]     prod_sh;

  assign prod     = x_i * s_i;
  assign prod_sh  = (W+1)'(prod >>> FRAC);
  assign s_next_o = prod_sh + c_i;

endmodule

// File: rtl/exp_m1_seq.sv
// Sequential e^x - 1 evaluator (Q0.16 in, Q1.16 out), Horner scheme on one shared multiplier.
// Optional argument range checking is enabled by defining EXP_RANGE_CHECK_EN.
module exp_m1_seq
  import exp_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [W:0] x_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic signed [W:0] f_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              range_err
);

  localparam int KW = $clog2(N + 1);

  state_t            state_q, state_d;
  logic signed [W:0] x_q, x_d;
  logic signed [W:0] s_q, s_d;
  logic signed [W:0] f_q, f_d;
  logic [KW-1:0]     k_q, k_d;
  logic              ov_q, ov_d;
  logic signed [W:0] coef;
  logic signed [W:0] s_next;

  assign coef = P[k_q];

  exp_mac_step #(.W(W)) u_mac (
    .x_i      (x_q),
    .s_i      (s_q),
    .c_i      (coef),
    .s_next_o (s_next)
  );

`ifdef EXP_RANGE_CHECK_EN
  localparam logic signed [W:0] X_MAX = (W+1)'(65535);
  logic re_q, re_d;
  logic x_bad;

  assign x_bad     = x_q[W] | (x_q > X_MAX);
  assign range_err = re_q;
`else
  assign range_err = 1'b0;
`endif

  assign in_ready  = reset && (state_q == IDLE);
  assign f_out     = f_q;
  assign out_valid = ov_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    s_d     = s_q;
    k_d     = k_q;
    f_d     = f_q;
    ov_d    = ov_q;
`ifdef EXP_RANGE_CHECK_EN
    re_d    = re_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = x_in;
          s_d     = P[N];
          k_d     = KW'(N - 1);
          state_d = MUL;
        end
      end
      MUL: begin
        s_d = s_next;
        k_d = k_q - 1'b1;
        if (k_q == '0) begin
          k_d     = k_q;
          f_d     = s_next;
          ov_d    = 1'b1;
          state_d = DONE;
        end
`ifdef EXP_RANGE_CHECK_EN
        // An out-of-range argument bypasses the iterations entirely
        if (x_bad) begin
          k_d     = k_q;
          f_d     = '0;
          ov_d    = 1'b1;
          re_d    = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (ov_q && out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
`ifdef EXP_RANGE_CHECK_EN
          re_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      f_q     <= '0;
      ov_q    <= 1'b0;
`ifdef EXP_RANGE_CHECK_EN
      re_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      f_q     <= f_d;
      ov_q    <= ov_d;
`ifdef EXP_RANGE_CHECK_EN
      re_q    <= re_d;
`endif
    end
  end

  // Argument register is pure data and only changes on an accept
  always_ff @(posedge clk) begin
    x_q <= x_d;
  end

endmodule

// File: tb/tb_exp_m1_seq.sv
// Directed testbench for exp_m1_seq: latency, hold, back-to-back, reset abort, accuracy, range check.
module tb_exp_m1_seq;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [17:0] x_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] f_out;
  logic               out_valid;
  logic               out_ready;
  logic               range_err;

  int checks = 0;
  int passed = 0;

  exp_m1_seq dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f_out     (f_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent Horner reference using 64-bit integers
  function automatic longint horner(input longint x);
    longint c [0:5];
    longint s;
    c = '{0, 65536, 32768, 10923, 2731, 546};
    s = c[5];
    for (int k = 4; k >= 0; k--) s = ((x * s) >>> 16) + c[k];
    return s;
  endfunction

  // Present x for one accepting edge, then wait (bounded) for out_valid; lat counts edges
  task automatic send_wait(input logic signed [17:0] x, output int lat, output bit ok);
    in_valid = 1'b1;
    x_in     = x;
    step();
    in_valid = 1'b0;
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_ov got %b want 0", out_valid); else passed++;
    checks++; if (f_out !== 18'sd0) $display("FAIL reset_f got %0d want 0", f_out); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passed++;
    checks++; if (range_err !== 1'b0) $display("FAIL reset_range_err got %b want 0", range_err); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_zero();
    logic signed [17:0] seq [0:4];
    seq = '{18'sd2731, 18'sd10923, 18'sd32768, 18'sd65536, 18'sd0};
    in_valid = 1'b1; x_in = 18'sd0;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) $display("FAIL zero_busy got %b want 0", in_ready); else passed++;
    checks++; if (dut.s_q !== 18'sd546) $display("FAIL zero_s_init got %0d want 546", dut.s_q); else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (dut.s_q !== seq[i]) $display("FAIL zero_s%0d got %0d want %0d", i, dut.s_q, seq[i]); else passed++;
      checks++; if (out_valid !== (i == 4)) $display("FAIL zero_ov%0d got %b want %b", i, out_valid, (i == 4)); else passed++;
    end
    checks++; if (f_out !== 18'sd0) $display("FAIL zero_f got %0d want 0", f_out); else passed++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL zero_release_ov got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL zero_release_rdy got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_hold();
    in_valid = 1'b1; x_in = 18'sd32768;
    step();
    in_valid = 1'b0;
    x_in = 18'sd9999;
    for (int i = 0; i < 5; i++) step();
    checks++; if (out_valid !== 1'b1) $display("FAIL half_ov got %b want 1", out_valid); else passed++;
    checks++; if (f_out !== 18'sd42513) $display("FAIL half_f got %0d want 42513", f_out); else passed++;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 0);
      step();
      checks++; if (out_valid !== 1'b1) $display("FAIL hold_ov%0d got %b want 1", i, out_valid); else passed++;
      checks++; if (f_out !== 18'sd42513) $display("FAIL hold_f%0d got %0d want 42513", i, f_out); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL hold_rdy%0d got %b want 0", i, in_ready); else passed++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL hold_release_ov got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL hold_release_rdy got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_back_to_back();
    logic signed [17:0] seq [0:4];
    int nres = 0;
    int last = 0;
    seq = '{18'sd3276, 18'sd14198, 18'sd46965, 18'sd112500, 18'sd112498};
    out_ready = 1'b1; in_valid = 1'b1; x_in = 18'sd65535;
    for (int e = 1; e <= 21; e++) begin
      step();
      if (e >= 2 && e <= 6) begin
        checks++; if (dut.s_q !== seq[e-2]) $display("FAIL b2b_s%0d got %0d want %0d", e, dut.s_q, seq[e-2]); else passed++;
      end
      if (out_valid) begin
        checks++; if (f_out !== 18'sd112498) $display("FAIL b2b_f_e%0d got %0d want 112498", e, f_out); else passed++;
        if (nres > 0) begin
          checks++; if (e - last !== 7) $display("FAIL b2b_interval got %0d want 7", e - last); else passed++;
        end
        nres++;
        last = e;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (nres !== 3) $display("FAIL b2b_count got %0d want 3", nres); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; bit ok;
    out_ready = 1'b0;
    in_valid = 1'b1; x_in = 18'sd32768;
    step();
    in_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_ov got %b want 0", out_valid); else passed++;
    checks++; if (f_out !== 18'sd0) $display("FAIL rst_mid_f got %0d want 0", f_out); else passed++;
    checks++; if (dut.s_q !== 18'sd0) $display("FAIL rst_mid_s got %0d want 0", dut.s_q); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_mid_rdy got %b want 0", in_ready); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_idle got %b want 1", in_ready); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) $display("FAIL stray_ready_ov%0d got %b want 0", i, out_valid); else passed++;
    end
    out_ready = 1'b0;
    send_wait(18'sd32768, lat, ok);
    checks++; if (!ok) $display("FAIL rst_mid_timeout got no out_valid want out_valid"); else passed++;
    checks++; if (lat !== 6) $display("FAIL rst_mid_latency got %0d want 6", lat); else passed++;
    checks++; if (f_out !== 18'sd42513) $display("FAIL rst_mid_f2 got %0d want 42513", f_out); else passed++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_accuracy();
    int lat; bit ok;
    longint xv, want;
    real ideal, err;
    for (int n = 0; n < 200; n++) begin
      case (n)
        0: xv = 1;
        1: xv = 65534;
        2: xv = 16384;
        default: xv = longint'($urandom_range(0, 65535));
      endcase
      want = horner(xv);
      send_wait(18'(xv), lat, ok);
      checks++; if (!ok) $display("FAIL acc_timeout x=%0d got no out_valid want out_valid", xv); else passed++;
      checks++; if (longint'(f_out) !== want) $display("FAIL acc_exact x=%0d got %0d want %0d", xv, f_out, want); else passed++;
      ideal = ($exp(real'(xv) / 65536.0) - 1.0) * 65536.0;
      err = real'(f_out) - ideal;
      if (err < 0.0) err = -err;
      checks++; if (err > 128.0) $display("FAIL acc_err x=%0d got %0d want within 128 of %f", xv, f_out, ideal); else passed++;
      checks++; if (range_err !== 1'b0) $display("FAIL acc_range_err x=%0d got %b want 0", xv, range_err); else passed++;
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
  endtask

`ifdef EXP_RANGE_CHECK_EN
  task automatic test_range();
    int lat; bit ok;
    logic signed [17:0] bad [0:1];
    bad = '{-18'sd1, 18'sd65536};
    for (int b = 0; b < 2; b++) begin
      send_wait(bad[b], lat, ok);
      checks++; if (!ok || lat !== 2) $display("FAIL range_latency x=%0d got %0d want 2", bad[b], lat); else passed++;
      checks++; if (f_out !== 18'sd0) $display("FAIL range_f x=%0d got %0d want 0", bad[b], f_out); else passed++;
      checks++; if (range_err !== 1'b1) $display("FAIL range_err x=%0d got %b want 1", bad[b], range_err); else passed++;
      step();
      checks++; if (range_err !== 1'b1 || out_valid !== 1'b1) $display("FAIL range_hold x=%0d got %b%b want 11", bad[b], range_err, out_valid); else passed++;
      out_ready = 1'b1; step(); out_ready = 1'b0;
      checks++; if (range_err !== 1'b0 || out_valid !== 1'b0) $display("FAIL range_clear x=%0d got %b%b want 00", bad[b], range_err, out_valid); else passed++;
    end
    send_wait(18'sd0, lat, ok);
    checks++; if (!ok || lat !== 6) $display("FAIL range_ok_latency got %0d want 6", lat); else passed++;
    checks++; if (range_err !== 1'b0) $display("FAIL range_ok_err got %b want 0", range_err); else passed++;
    checks++; if (f_out !== 18'sd0) $display("FAIL range_ok_f got %0d want 0", f_out); else passed++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_accuracy();
`ifdef EXP_RANGE_CHECK_EN
    test_range();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
